// File: rtl/packet_register_controller_pkg.sv
`default_nettype none
// packet_register_controller_pkg: shared packet beat type, command bytes and controller states.
package packet_register_controller_pkg;

  typedef struct packed {
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic [7:0] Data;
    logic       SoP;
    logic       EoP;
    logic       Valid;
  } UART_PACKET;

  localparam logic [7:0] CMD_READ  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] ACK_BYTE  = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_ADDR  = 3'd1,
    ST_GET_DATA  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_READ_WAIT = 3'd4,
    ST_SEND      = 3'd5,
    ST_DISCARD   = 3'd6
  } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/packet_tx_serialiser.sv
`default_nettype none
// packet_tx_serialiser: emits a response packet one byte per beat, MSB first,
// holding each beat unchanged until the sink accepts it.
module packet_tx_serialiser
  import packet_register_controller_pkg::*;
#(
  parameter int BLOCK_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [BLOCK_WIDTH-1:0] payload,
  input  logic [7:0]             count,
  input  logic [7:0]             dest,
  input  logic [7:0]             src,
  input  logic                   tx_ready,
  output UART_PACKET             tx_stream,
  output logic                   last_accept
);

  logic [BLOCK_WIDTH-1:0] shift_q;
  logic [7:0]             remaining_q;
  logic [7:0]             dest_q;
  logic [7:0]             src_q;
  logic [7:0]             length_q;
  logic                   valid_q;
  logic                   sop_q;
  logic                   eop_q;
  logic                   accept;

  assign accept      = valid_q && tx_ready;
  assign last_accept = accept && (remaining_q == 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q     <= '0;
      remaining_q <= 8'd0;
      dest_q      <= 8'd0;
      src_q       <= 8'd0;
      length_q    <= 8'd0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
    end else if (load) begin
      shift_q     <= payload;
      remaining_q <= count;
      dest_q      <= dest;
      src_q       <= src;
      length_q    <= count;
      valid_q     <= 1'b1;
      sop_q       <= 1'b1;
      eop_q       <= (count == 8'd1);
    end else if (accept) begin
      sop_q <= 1'b0;
      if (remaining_q == 8'd1) begin
        valid_q <= 1'b0;
        eop_q   <= 1'b0;
      end else begin
        // The byte on the bus is always the top byte of the shift register.
        shift_q     <= shift_q << 8;
        remaining_q <= remaining_q - 8'd1;
        eop_q       <= (remaining_q == 8'd2);
      end
    end
  end

  assign tx_stream.Source      = src_q;
  assign tx_stream.Destination = dest_q;
  assign tx_stream.Length      = length_q;
  assign tx_stream.Data        = shift_q[BLOCK_WIDTH-1 -: 8];
  assign tx_stream.SoP         = sop_q;
  assign tx_stream.EoP         = eop_q;
  assign tx_stream.Valid       = valid_q;

endmodule
`default_nettype wire

// File: rtl/packet_register_controller.sv
`default_nettype none
// packet_register_controller: parses Rx command packets into register reads/writes and returns
// read data on Tx. Define PACKET_REGISTER_CONTROLLER_WRITE_ACK_EN to acknowledge writes.
module packet_register_controller
  import packet_register_controller_pkg::*;
#(
  parameter int         BLOCK_WIDTH   = 32,
  parameter logic [7:0] LOCAL_ADDRESS = 8'h10
) (
  input  logic                   ipClk,
  input  logic                   ipReset,
  input  UART_PACKET             ipRxStream,
  output UART_PACKET             opTxStream,
  input  logic                   ipTxReady,
  output logic [7:0]             opAddress,
  output logic [BLOCK_WIDTH-1:0] opWrData,
  output logic                   opWrEnable,
  input  logic [BLOCK_WIDTH-1:0] ipRdData,
  output logic                   opRxDropped
);

  localparam int         BYTES     = BLOCK_WIDTH / 8;
  localparam logic [7:0] BYTES_U8  = 8'(BYTES);
  localparam logic [7:0] READ_LEN  = 8'd2;
  localparam logic [7:0] WRITE_LEN = 8'(2 + BYTES);
  localparam logic [7:0] LAST_IDX  = 8'(BYTES - 1);

  ctrl_state_t            state;
  ctrl_state_t            start_next;
  ctrl_state_t            after_busy;
  logic [7:0]             src_q;
  logic [7:0]             len_q;
  logic [7:0]             cmd_q;
  logic [7:0]             byte_cnt;
  logic [7:0]             address_q;
  logic [BLOCK_WIDTH-1:0] data_shift;
  logic [BLOCK_WIDTH-1:0] data_final;
  logic [BLOCK_WIDTH-1:0] wr_data_q;
  logic                   wr_en_q;
  logic                   dropped_q;
  logic                   discard_pending;
  logic                   pending_next;
  logic                   parsing;
  logic                   busy;
  logic                   rx_start;
  logic                   drop_beat;

  logic                   tx_load;
  logic [BLOCK_WIDTH-1:0] tx_payload;
  logic [7:0]             tx_count;
  logic                   tx_last_accept;

  assign parsing    = (state == ST_IDLE) || (state == ST_GET_ADDR) || (state == ST_GET_DATA);
  assign busy       = (state == ST_WRITE) || (state == ST_READ_WAIT) || (state == ST_SEND);
  assign rx_start   = ipRxStream.Valid && ipRxStream.SoP;
  assign drop_beat  = ipRxStream.Valid && busy;
  assign data_final = (data_shift << 8) | BLOCK_WIDTH'(ipRxStream.Data);

  // A beat dropped mid-packet leaves the rest of that packet to be swallowed once we are idle.
  assign pending_next = drop_beat ? !ipRxStream.EoP : discard_pending;
  assign after_busy   = pending_next ? ST_DISCARD : ST_IDLE;

  // Single-beat packets are malformed and simply ignored.
  assign start_next = ipRxStream.EoP ? ST_IDLE :
                      (ipRxStream.Destination == LOCAL_ADDRESS) ? ST_GET_ADDR : ST_DISCARD;

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state           <= ST_IDLE;
      src_q           <= 8'd0;
      len_q           <= 8'd0;
      cmd_q           <= 8'd0;
      byte_cnt        <= 8'd0;
      address_q       <= 8'd0;
      data_shift      <= '0;
      wr_data_q       <= '0;
      wr_en_q         <= 1'b0;
      dropped_q       <= 1'b0;
      discard_pending <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      dropped_q <= drop_beat;
      if (parsing && rx_start) begin
        state <= start_next;
        src_q <= ipRxStream.Source;
        len_q <= ipRxStream.Length;
        cmd_q <= ipRxStream.Data;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_GET_ADDR: begin
            if (ipRxStream.Valid) begin
              if (cmd_q == CMD_READ && len_q == READ_LEN && ipRxStream.EoP) begin
                address_q <= ipRxStream.Data;
                state     <= ST_READ_WAIT;
              end else if (cmd_q == CMD_WRITE && len_q == WRITE_LEN && !ipRxStream.EoP) begin
                address_q  <= ipRxStream.Data;
                byte_cnt   <= 8'd0;
                data_shift <= '0;
                state      <= ST_GET_DATA;
              end else begin
                state <= ipRxStream.EoP ? ST_IDLE : ST_DISCARD;
              end
            end
          end
          ST_GET_DATA: begin
            if (ipRxStream.Valid) begin
              data_shift <= data_final;
              if (byte_cnt == LAST_IDX) begin
                if (ipRxStream.EoP) begin
                  wr_data_q <= data_final;
                  wr_en_q   <= 1'b1;
                  state     <= ST_WRITE;
                end else begin
                  state <= ST_DISCARD;
                end
              end else if (ipRxStream.EoP) begin
                state <= ST_IDLE;
              end else begin
                byte_cnt <= byte_cnt + 8'd1;
              end
            end
          end
          ST_WRITE: begin
`ifdef PACKET_REGISTER_CONTROLLER_WRITE_ACK_EN
            state           <= ST_SEND;
            discard_pending <= pending_next;
`else
            state           <= after_busy;
            discard_pending <= 1'b0;
`endif
          end
          ST_READ_WAIT: begin
            state           <= ST_SEND;
            discard_pending <= pending_next;
          end
          ST_SEND: begin
            if (tx_last_accept) begin
              state           <= after_busy;
              discard_pending <= 1'b0;
            end else begin
              discard_pending <= pending_next;
            end
          end
          ST_DISCARD: begin
            if (ipRxStream.Valid && ipRxStream.EoP) begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // The serialiser captures read data at the end of the single READ_WAIT cycle.
`ifdef PACKET_REGISTER_CONTROLLER_WRITE_ACK_EN
  assign tx_load    = (state == ST_READ_WAIT) || (state == ST_WRITE);
  assign tx_payload = (state == ST_WRITE) ? (BLOCK_WIDTH'(ACK_BYTE) << (BLOCK_WIDTH - 8)) : ipRdData;
  assign tx_count   = (state == ST_WRITE) ? 8'd1 : BYTES_U8;
`else
  assign tx_load    = (state == ST_READ_WAIT);
  assign tx_payload = ipRdData;
  assign tx_count   = BYTES_U8;
`endif

  packet_tx_serialiser #(
    .BLOCK_WIDTH(BLOCK_WIDTH)
  ) u_tx (
    .clk        (ipClk),
    .rst        (ipReset),
    .load       (tx_load),
    .payload    (tx_payload),
    .count      (tx_count),
    .dest       (src_q),
    .src        (LOCAL_ADDRESS),
    .tx_ready   (ipTxReady),
    .tx_stream  (opTxStream),
    .last_accept(tx_last_accept)
  );

  assign opAddress   = address_q;
  assign opWrData    = wr_data_q;
  assign opWrEnable  = wr_en_q;
  assign opRxDropped = dropped_q;

endmodule
`default_nettype wire
